alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-cycle registered ALU execute stage with PC adders.
// Optional signed-overflow flag output enabled by ALU_OVERFLOW_EN.
module alu_exec_unit #(
  parameter int unsigned PC_INC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  aluop,
  input  logic [3:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] br_off,
`ifdef ALU_OVERFLOW_EN
  output logic        ovf,
`endif
  output logic        out_valid,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SLL = 3'b011;
  localparam logic [2:0] CTL_NOR = 3'b100;
  localparam logic [2:0] CTL_SRL = 3'b101;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [31:0] INC = PC_INC[31:0];

  logic [2:0]  ctl;
  logic [31:0] res;
  logic [31:0] pc4;

  logic        out_valid_d, out_valid_q;
  logic [2:0]  alu_ctl_d, alu_ctl_q;
  logic [31:0] result_d, result_q;
  logic        zero_d, zero_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;
  logic [31:0] br_target_d, br_target_q;

  always_comb begin
    ctl = CTL_ADD;
    unique case (aluop)
      2'b00: ctl = CTL_ADD;
      2'b01: ctl = CTL_SUB;
      2'b10: begin
        unique case (funct)
          4'b0000: ctl = CTL_ADD;
          4'b0010: ctl = CTL_SUB;
          4'b0100: ctl = CTL_AND;
          4'b0101: ctl = CTL_OR;
          4'b0111: ctl = CTL_NOR;
          4'b1010: ctl = CTL_SLT;
          default: ctl = CTL_ADD;
        endcase
      end
      2'b11: ctl = funct[1] ? CTL_SRL : CTL_SLL;
      default: ctl = CTL_ADD;
    endcase
  end

  always_comb begin
    res = 32'd0;
    unique case (ctl)
      CTL_AND: res = a & b;
      CTL_OR:  res = a | b;
      CTL_ADD: res = a + b;
      CTL_SUB: res = a - b;
      CTL_NOR: res = ~(a | b);
      CTL_SLT: res = {31'd0, $signed(a) < $signed(b)};
      CTL_SLL: res = b << shamt;
      CTL_SRL: res = b >> shamt;
      default: res = 32'd0;
    endcase
  end

  assign pc4 = pc + INC;

  always_comb begin
    out_valid_d = in_valid;
    alu_ctl_d   = alu_ctl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    pc_plus4_d  = pc_plus4_q;
    br_target_d = br_target_q;
    if (in_valid) begin
      alu_ctl_d   = ctl;
      result_d    = res;
      zero_d      = (res == 32'd0);
      pc_plus4_d  = pc4;
      br_target_d = pc4 + br_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctl_q   <= 3'd0;
      result_q    <= 32'd0;
      zero_q      <= 1'b0;
      pc_plus4_q  <= 32'd0;
      br_target_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_ctl_q   <= alu_ctl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      pc_plus4_q  <= pc_plus4_d;
      br_target_q <= br_target_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctl   = alu_ctl_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign pc_plus4  = pc_plus4_q;
  assign br_target = br_target_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_c;
  logic ovf_d, ovf_q;

  // Overflow iff result sign disagrees with a when b's sign permits it.
  always_comb begin
    ovf_c = 1'b0;
    if (ctl == CTL_ADD)
      ovf_c = (a[31] == b[31]) && (res[31] != a[31]);
    else if (ctl == CTL_SUB)
      ovf_c = (a[31] != b[31]) && (res[31] != a[31]);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = ovf_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  aluop = '0;
  logic [3:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] a = '0, b = '0, pc = '0, br_off = '0;
  logic        out_valid, zero;
  logic [2:0]  alu_ctl;
  logic [31:0] result, pc_plus4, br_target;
`ifdef ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int total = 0;
  int bad = 0;

  logic        e_valid = 0, e_zero = 0, e_ovf = 0;
  logic [2:0]  e_ctl = 0;
  logic [31:0] e_res = 0, e_pc4 = 0, e_bt = 0;

  alu_exec_unit #(.PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .aluop(aluop), .funct(funct), .shamt(shamt),
    .a(a), .b(b), .pc(pc), .br_off(br_off),
`ifdef ALU_OVERFLOW_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid), .alu_ctl(alu_ctl),
    .result(result), .zero(zero),
    .pc_plus4(pc_plus4), .br_target(br_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".ctl"}, 32'(alu_ctl), 32'(e_ctl));
    chk({tag, ".result"}, result, e_res);
    chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
    chk({tag, ".pc4"}, pc_plus4, e_pc4);
    chk({tag, ".btgt"}, br_target, e_bt);
`ifdef ALU_OVERFLOW_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
`endif
  endtask

  // Reference: pick the operation by name, then evaluate with
  // wide signed arithmetic and truncate.
  task automatic model(input logic [1:0] op, input logic [3:0] f,
                       input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [2:0] c, output logic [31:0] r,
                       output logic v);
    string nm;
    longint sx, sy, t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == 2'd0) nm = "add";
    else if (op == 2'd1) nm = "sub";
    else if (op == 2'd3) nm = f[1] ? "srl" : "sll";
    else if (f == 4'd2) nm = "sub";
    else if (f == 4'd4) nm = "and";
    else if (f == 4'd5) nm = "or";
    else if (f == 4'd7) nm = "nor";
    else if (f == 4'd10) nm = "slt";
    else nm = "add";
    v = 1'b0;
    t = 0;
    c = 3'd2; r = 32'd0;
    if (nm == "add") begin
      t = sx + sy; c = 3'd2; r = 32'(t);
      v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    end else if (nm == "sub") begin
      t = sx - sy; c = 3'd6; r = 32'(t);
      v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    end else if (nm == "and") begin c = 3'd0; r = x & y; end
    else if (nm == "or") begin c = 3'd1; r = x | y; end
    else if (nm == "nor") begin c = 3'd4; r = ~(x | y); end
    else if (nm == "slt") begin c = 3'd7; r = (sx < sy) ? 32'd1 : 32'd0; end
    else if (nm == "sll") begin
      c = 3'd3; r = 32'(longint'(y) * (longint'(1) << sh));
    end else begin
      c = 3'd5; r = 32'(longint'(y) / (longint'(1) << sh));
    end
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [1:0] op, input logic [3:0] f,
                      input logic [4:0] sh,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, input logic [31:0] off);
    logic [2:0]  c;
    logic [31:0] r;
    logic        ov;
    in_valid = v; aluop = op; funct = f; shamt = sh;
    a = x; b = y; pc = p; br_off = off;
    @(posedge clk);
    #1;
    e_valid = v;
    if (v) begin
      model(op, f, sh, x, y, c, r, ov);
      e_ctl = c; e_res = r; e_zero = (r == 0); e_ovf = ov;
      e_pc4 = 32'(longint'(p) + 4);
      e_bt = 32'(longint'(p) + 4 + longint'(off));
    end
    chk_all(tag);
  endtask

  task automatic clear_exp();
    e_valid = 0; e_ctl = 0; e_res = 0; e_zero = 0;
    e_pc4 = 0; e_bt = 0; e_ovf = 0;
  endtask

  initial begin
    #1;
    clear_exp();
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_reset_idle");

    step("add_5_7", 1, 2'b00, 4'd0, 5'd0, 32'd5, 32'd7, 32'd0, 32'd8);
    chk("add_5_7.lit", result, 32'd12);
    step("sub_eq", 1, 2'b01, 4'd0, 5'd0, 32'h1234, 32'h1234, 32'h100, 32'h0);
    chk("sub_eq.zero", 32'(zero), 32'd1);
    step("sub_neg", 1, 2'b01, 4'd0, 5'd0, 32'd0, 32'd1, 32'h200, 32'hFFFF_FFF0);
    chk("sub_neg.lit", result, 32'hFFFF_FFFF);
    step("and", 1, 2'b10, 4'b0100, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
    chk("and.lit", result, 32'h00F0_00F0);
    step("or", 1, 2'b10, 4'b0101, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
    chk("or.lit", result, 32'hFFF0_FFF0);
    step("nor", 1, 2'b10, 4'b0111, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
    chk("nor.lit", result, 32'h000F_000F);
    step("slt_m1_1", 1, 2'b10, 4'b1010, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    chk("slt_m1_1.lit", result, 32'd1);
    step("slt_max_min", 1, 2'b10, 4'b1010, 5'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    chk("slt_max_min.lit", result, 32'd0);
    step("slt_ovf", 1, 2'b10, 4'b1010, 5'd0, 32'h8000_0000, 32'd1, 0, 0);
    step("fsub", 1, 2'b10, 4'b0010, 5'd0, 32'd3, 32'd9, 0, 0);
    step("fdflt", 1, 2'b10, 4'b1111, 5'd0, 32'd3, 32'd9, 0, 0);
    step("sll4", 1, 2'b11, 4'b0000, 5'd4, 32'd0, 32'h8000_0001, 0, 0);
    chk("sll4.lit", result, 32'h0000_0010);
    step("srl4", 1, 2'b11, 4'b0010, 5'd4, 32'd0, 32'h8000_0001, 32'hFFFF_FFFC, 0);
    chk("srl4.lit", result, 32'h0800_0000);
    chk("pc_wrap.lit", pc_plus4, 32'd0);
    step("sll0", 1, 2'b11, 4'b0000, 5'd0, 0, 32'hDEAD_BEEF, 0, 0);
    step("srl31", 1, 2'b11, 4'b0010, 5'd31, 0, 32'hDEAD_BEEF, 0, 0);
    step("sll31", 1, 2'b11, 4'b0000, 5'd31, 0, 32'hDEAD_BEEF, 0, 0);
    step("add_ovf", 1, 2'b00, 4'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 0, 0);
`ifdef ALU_OVERFLOW_EN
    chk("add_ovf.lit", 32'(ovf), 32'd1);
`endif
    step("sub_ovf", 1, 2'b01, 4'd0, 5'd0, 32'h8000_0000, 32'd1, 0, 0);
    step("hold1", 0, 2'b01, 4'd3, 5'd7, 32'h55, 32'h66, 32'h77, 32'h88);
    step("hold2", 0, 2'b10, 4'd5, 5'd1, 32'h1, 32'h2, 32'h3, 32'h4);

    step("pre_rst", 1, 2'b00, 4'd0, 5'd0, 32'd10, 32'd20, 32'h40, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    chk_all("async_rst");
    in_valid = 1'b1;
    a = 32'd99;
    @(posedge clk);
    #1;
    chk_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_idle", 0, 2'b00, 4'd0, 5'd0, 32'd1, 32'd1, 32'd8, 0);
    step("post_rst_op", 1, 2'b00, 4'd0, 5'd0, 32'd1, 32'd1, 32'd8, 0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] fs [7];
      logic [3:0] f;
      fs = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd10, 4'd9};
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                       : fs[$urandom_range(0, 6)];
      step("rand", ($urandom_range(0, 4) != 0), 2'($urandom), f,
           5'($urandom), $urandom, $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
